// File: rtl/sine_dds.sv
// Sine-wave DDS sample source: phase accumulator advanced on each sample tick,
// converted to a 10-bit offset-binary sample through a quarter-wave table.
module sine_dds #(
  parameter int ACC_W = 16,
  parameter int INC_W = 10,
  parameter int OUT_W = 10
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid
);

  // T[a] = round(511 * sin((pi/2) * (a + 0.5) / 64)); the half-step offset keeps quadrants point-symmetric.
  function automatic logic [8:0] quarter_sine(input logic [5:0] a);
    logic [8:0] t;
    case (a)
      6'd0:  t = 9'd6;   6'd1:  t = 9'd19;  6'd2:  t = 9'd31;  6'd3:  t = 9'd44;
      6'd4:  t = 9'd56;  6'd5:  t = 9'd69;  6'd6:  t = 9'd81;  6'd7:  t = 9'd94;
      6'd8:  t = 9'd106; 6'd9:  t = 9'd118; 6'd10: t = 9'd130; 6'd11: t = 9'd142;
      6'd12: t = 9'd154; 6'd13: t = 9'd166; 6'd14: t = 9'd178; 6'd15: t = 9'd190;
      6'd16: t = 9'd201; 6'd17: t = 9'd213; 6'd18: t = 9'd224; 6'd19: t = 9'd235;
      6'd20: t = 9'd246; 6'd21: t = 9'd257; 6'd22: t = 9'd268; 6'd23: t = 9'd279;
      6'd24: t = 9'd289; 6'd25: t = 9'd299; 6'd26: t = 9'd309; 6'd27: t = 9'd319;
      6'd28: t = 9'd329; 6'd29: t = 9'd338; 6'd30: t = 9'd348; 6'd31: t = 9'd357;
      6'd32: t = 9'd366; 6'd33: t = 9'd374; 6'd34: t = 9'd383; 6'd35: t = 9'd391;
      6'd36: t = 9'd399; 6'd37: t = 9'd407; 6'd38: t = 9'd414; 6'd39: t = 9'd421;
      6'd40: t = 9'd428; 6'd41: t = 9'd435; 6'd42: t = 9'd441; 6'd43: t = 9'd448;
      6'd44: t = 9'd454; 6'd45: t = 9'd459; 6'd46: t = 9'd465; 6'd47: t = 9'd470;
      6'd48: t = 9'd474; 6'd49: t = 9'd479; 6'd50: t = 9'd483; 6'd51: t = 9'd487;
      6'd52: t = 9'd491; 6'd53: t = 9'd494; 6'd54: t = 9'd497; 6'd55: t = 9'd500;
      6'd56: t = 9'd502; 6'd57: t = 9'd505; 6'd58: t = 9'd506; 6'd59: t = 9'd508;
      6'd60: t = 9'd509; 6'd61: t = 9'd510; 6'd62: t = 9'd511;
      default: t = 9'd511;
    endcase
    return t;
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             v1_q, v2_q, valid_q;
  logic [8:0]       tab_q, tab_d;
  logic [1:0]       quad_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic [7:0]       idx;
  logic [5:0]       addr;

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = acc_q + ACC_W'(inc);
    end
    idx   = acc_q[ACC_W-1 -: 8];
    // Odd quadrants walk the table backwards.
    addr  = idx[6] ? ~idx[5:0] : idx[5:0];
    tab_d = quarter_sine(addr);
    if (quad_q[1]) begin
      out_d = OUT_W'(10'd511 - {1'b0, tab_q});
    end else begin
      out_d = OUT_W'(10'd512 + {1'b0, tab_q});
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      tab_q   <= '0;
      quad_q  <= '0;
      out_q   <= OUT_W'(512);
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      v1_q    <= en;
      v2_q    <= v1_q;
      tab_q   <= tab_d;
      quad_q  <= idx[7:6];
      valid_q <= v2_q;
      if (v2_q) begin
        out_q <= out_d;
      end
    end
  end

  assign data_out   = out_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_sine_dds.sv
// Directed bench for sine_dds: a 16-bit accumulator instance and a 12-bit one,
// checked against hand-computed samples from the quarter-wave table formula.
module tb_sine_dds;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [10:0] inc_a, inc_b;
  logic [9:0]  data_a, data_b;
  logic        valid_a, valid_b;
  logic        vseen;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_b[4] = '{1023, 505, 0, 518};

  always #5 clk = ~clk;

  sine_dds #(.ACC_W(16), .INC_W(11), .OUT_W(10)) dut_a (
    .sysclk(clk), .rst(rst), .en(en_a), .inc(inc_a),
    .data_out(data_a), .data_valid(valid_a)
  );

  sine_dds #(.ACC_W(12), .INC_W(11), .OUT_W(10)) dut_b (
    .sysclk(clk), .rst(rst), .en(en_b), .inc(inc_b),
    .data_out(data_b), .data_valid(valid_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic step_a;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
  endtask

  // One tick on the selected instance; expects valid two edges later for one cycle.
  task automatic pulse(input bit sel, input string tag, input int exp);
    int lat;
    int obs;
    if (sel) en_b = 1'b1;
    else     en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
    lat = 0;
    while (!(sel ? valid_b : valid_a) && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    obs = sel ? int'(data_b) : int'(data_a);
    $display("txn %s: data_out=%0d latency=%0d", tag, obs, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_data"}, obs, exp);
    @(negedge clk);
    check({tag, "_onecycle"}, int'(sel ? valid_b : valid_a), 0);
  endtask

  initial begin
    rst   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    inc_a = 11'd0;
    inc_b = 11'h400;
    cycles(3);
    check("rst_data_a", int'(data_a), 512);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_data_b", int'(data_b), 512);

    rst   = 1'b0;
    vseen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vseen = vseen | valid_a | valid_b;
    end
    $display("txn idle: data_out=%0d", data_a);
    check("idle_no_valid", int'(vseen), 0);
    check("idle_data", int'(data_a), 512);

    // Frozen phase repeats T[0].
    pulse(1'b0, "inc0_first", 518);
    pulse(1'b0, "inc0_second", 518);

    do_reset;
    inc_a = 11'd1024;
    pulse(1'b0, "inc1024_p1", 568);
    repeat (30) step_a;
    cycles(3);
    pulse(1'b0, "inc1024_p32", 505);
    repeat (31) step_a;
    cycles(3);
    pulse(1'b0, "inc1024_p64_wrap", 518);

    // 12-bit accumulator: one quadrant per tick.
    do_reset;
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, $sformatf("acc12_p%0d", k + 1), exp_b[k]);
      cycles(17);
      check($sformatf("acc12_hold%0d", k + 1), int'(data_b), exp_b[k]);
    end

    // Back-to-back ticks stream three samples.
    do_reset;
    inc_a = 11'd1024;
    en_a  = 1'b1;
    cycles(3);
    en_a  = 1'b0;
    $display("txn burst1: data_out=%0d valid=%0d", data_a, valid_a);
    check("burst1_valid", int'(valid_a), 1);
    check("burst1_data", int'(data_a), 568);
    cycles(1);
    $display("txn burst2: data_out=%0d valid=%0d", data_a, valid_a);
    check("burst2_valid", int'(valid_a), 1);
    check("burst2_data", int'(data_a), 618);
    cycles(1);
    $display("txn burst3: data_out=%0d valid=%0d", data_a, valid_a);
    check("burst3_valid", int'(valid_a), 1);
    check("burst3_data", int'(data_a), 666);
    cycles(1);
    check("burst_end_valid", int'(valid_a), 0);
    check("burst_end_hold", int'(data_a), 666);

    // Reset lands mid-pipeline, between clock edges.
    step_a;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("txn async_rst: data_out=%0d valid=%0d", data_a, valid_a);
    check("async_data", int'(data_a), 512);
    check("async_valid", int'(valid_a), 0);
    cycles(2);
    rst   = 1'b0;
    vseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vseen = vseen | valid_a;
    end
    check("async_no_pulse", int'(vseen), 0);
    pulse(1'b0, "after_async", 568);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
